dc_shift_driver: RTL and testbench
==================================

Name: dc_shift_driver

Overview:
Transaction-level driver for the 3-stage digital core shift chain; sits directly upstream of it and consumes its serial output.
- Accepts a parallel WIDTH-bit word and paces it out MSB-first on dc_digital_input, using one-cycle dc_clk_enable strobes.
- Collects the word returned on dc_digital_output after the core's pipeline depth, and presents it in parallel with a done pulse.
- Used for loopback and scan testing of the core from the FPGA/JTAG side.

Parameters:
WIDTH, 8, payload bits per transfer (>=1)
DIV, 4, internal_clk cycles per enable strobe (>=1; DIV=1 gives continuous enable)
CORE_DEPTH, 3, shift stages in the downstream core (>=1)

Ports:
internal_clk  input  1  block clock; one clock domain only
dc_rst  input  1  reset; asynchronous assert, active-high, all state cleared
start_i  input  1  transfer request, sampled on the rising edge
tx_data_i  input  WIDTH  word to send, captured when start is accepted
busy_o  output  1  high from the cycle after acceptance through the done cycle
done_o  output  1  one-cycle pulse; rx_data_o is valid from this cycle on
rx_data_o  output  WIDTH  word returned from the core; held until the next done
dc_clk_enable  output  1  shift strobe to the core
dc_digital_input  output  1  serial bit to the core
dc_digital_output  input  1  serial bit from the core (last stage)

Behaviour:
- Clock and reset: one clock, internal_clk. dc_rst is asynchronous and active-high.
- Reset values: all outputs 0, rx_data_o 0, state IDLE.
- Reset mid-transfer: dc_clk_enable drops immediately (asynchronously); the transfer is abandoned with no done pulse.
- States: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE:
  - start_i=1 is accepted: tx_data_i latched into the tx shift register, pulse counter = 0, divider = 0, go to SHIFT.
  - dc_digital_input = 0.
- Total strobes per transfer: N = WIDTH + CORE_DEPTH.
- Timing (start sampled at the end of cycle 0):
  - busy_o = 1 from cycle 1.
  - dc_clk_enable = 1 in cycles DIV*k, k = 1..N, and 0 otherwise.
  - Divider counts 0..DIV-1; the strobe fires when it reaches DIV-1.
- Transmit:
  - dc_digital_input is stable across each strobe period.
  - Period k (the cycles up to and including strobe k) carries tx bit WIDTH-k for k <= WIDTH, then 0 (flush) for k > WIDTH.
  - dc_digital_input updates in the cycle after each strobe.
- Receive:
  - In each strobe cycle k, dc_digital_output is sampled before the core shifts.
  - Samples for k = 1..CORE_DEPTH are discarded (stale core contents).
  - Samples for k = CORE_DEPTH+1..N are shifted into the rx register MSB-first.
  - Result: a loopback through a CORE_DEPTH-stage core returns tx_data exactly.
- After strobe N: state DONE in cycle DIV*N+1.
  - done_o = 1 and rx_data_o is updated (registered) in that cycle.
  - busy_o is still 1 in that cycle and 0 from cycle DIV*N+2 (IDLE).
- start_i while busy (SHIFT or DONE): ignored; tx_data_i is not re-latched.
- start_i in the first IDLE cycle after DONE: accepted normally, giving back-to-back transfers.
- rx_data_o is never partially updated; it changes only in the done cycle.
- Counters:
  - Pulse counter is sized ceil(log2(N+1)); divider is sized ceil(log2(DIV)), minimum 1 bit.
  - No wrap-around occurs within a transfer.

Test Plan:
- Loopback with a 3-stage core, WIDTH=8, DIV=4, tx=0xA5 -> 11 strobes at cycles 4,8,...,44; done_o only at cycle 45; rx_data_o=0xA5; busy_o low at cycle 46.
- Strobe shape with DIV=1, tx=0x3C -> dc_clk_enable high in cycles 1..11 continuously; done at cycle 12; rx=0x3C.
- Core output stuck 1 -> rx=0xFF; stuck 0 -> rx=0x00.
  - Previous rx_data_o is held unchanged until the done cycle.
- start_i pulsed with tx=0x00 at cycle 20 during a 0xA5 transfer -> no restart, rx=0xA5.
  - Then start in the first IDLE cycle with tx=0x5A -> second done 45 cycles later, rx=0x5A.
- dc_rst asserted at cycle 17 (mid-SHIFT, between edges) -> dc_clk_enable, busy_o and dc_digital_input are 0 immediately; rx_data_o=0; no done_o.
  - A new start after release completes normally.
- WIDTH=1, CORE_DEPTH=1, DIV=2, tx=1 -> strobes at cycles 2,4; done at cycle 5; rx=1.

Source files
------------

// File: rtl/dc_shift_driver.sv
// dc_shift_driver: paces a parallel word MSB-first into the digital core shift
// chain using one-cycle enable strobes, then returns the word read back from
// the chain's last stage as a parallel result with a done pulse.
module dc_shift_driver #(
  parameter int WIDTH      = 8,
  parameter int DIV        = 4,
  parameter int CORE_DEPTH = 3
) (
  input  logic             internal_clk,
  input  logic             dc_rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] tx_data_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] rx_data_o,
  output logic             dc_clk_enable,
  output logic             dc_digital_input,
  input  logic             dc_digital_output
);

  // Each transfer needs WIDTH payload strobes plus CORE_DEPTH flush strobes
  // to push the payload all the way through the core and back out.
  localparam int N  = WIDTH + CORE_DEPTH;
  localparam int CW = $clog2(N + 1);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CW-1:0] LAST_PULSE = CW'(N - 1);
  localparam logic [CW-1:0] FIRST_KEEP = CW'(CORE_DEPTH);
  localparam logic [DW-1:0] DIV_LAST   = DW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [WIDTH-1:0] rx_shifted;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    div_q, div_d;
  logic             strobe;

  // The strobe is a pure decode of registered state, so an asynchronous reset
  // removes it in the same instant without waiting for a clock edge.
  assign strobe     = (state_q == SHIFT) && (div_q == DIV_LAST);
  assign rx_shifted = (rx_sh_q << 1) | WIDTH'(dc_digital_output);

  assign busy_o           = (state_q != IDLE);
  assign done_o           = (state_q == DONE);
  assign rx_data_o        = rx_q;
  assign dc_clk_enable    = strobe;
  assign dc_digital_input = (state_q == SHIFT) && tx_q[WIDTH-1];

  // Next-state logic: acceptance, strobe pacing, serial tx/rx and completion.
  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    tx_d    = tx_q;
    rx_sh_d = rx_sh_q;
    rx_d    = rx_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          tx_d    = tx_data_i;
          rx_sh_d = '0;
          cnt_d   = '0;
          div_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (strobe) begin
          div_d = '0;
          // Zeros shift in behind the payload and serve as the flush bits.
          tx_d  = tx_q << 1;
          cnt_d = cnt_q + CW'(1);
          // The first CORE_DEPTH samples are whatever the core held before.
          if (cnt_q >= FIRST_KEEP) begin
            rx_sh_d = rx_shifted;
          end
          if (cnt_q == LAST_PULSE) begin
            rx_d    = rx_shifted;
            state_d = DONE;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers, all cleared by the asynchronous reset.
  always_ff @(posedge internal_clk or posedge dc_rst) begin
    if (dc_rst) begin
      state_q <= IDLE;
      tx_q    <= '0;
      rx_sh_q <= '0;
      rx_q    <= '0;
      cnt_q   <= '0;
      div_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_sh_q <= rx_sh_d;
      rx_q    <= rx_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
    end
  end

endmodule

// File: tb/tb_dc_shift_driver.sv
// Bench for dc_shift_driver: three instances (default pacing, continuous
// enable, minimal width/depth), each looped back through a behavioural core.
module tb_dc_shift_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       start [3];
  logic [7:0] txv   [3];
  logic       busy  [3];
  logic       done  [3];
  logic       en    [3];
  logic       din   [3];
  logic       dout  [3];
  logic [7:0] rx0, rx1;
  logic       rx2b;
  int         mode;           // u0 core output: 0 loopback, 1 stuck 1, 2 stuck 0

  logic [2:0] core0 = '0;
  logic [2:0] core1 = '0;
  logic       core2 = 1'b0;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb [$];

  always #5 clk = ~clk;

  // Behavioural shift cores downstream of each driver.
  always @(posedge clk) if (en[0]) core0 <= {core0[1:0], din[0]};
  always @(posedge clk) if (en[1]) core1 <= {core1[1:0], din[1]};
  always @(posedge clk) if (en[2]) core2 <= din[2];

  assign dout[0] = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : core0[2];
  assign dout[1] = core1[2];
  assign dout[2] = core2;

  dc_shift_driver #(.WIDTH(8), .DIV(4), .CORE_DEPTH(3)) u0 (
    .internal_clk(clk), .dc_rst(rst), .start_i(start[0]), .tx_data_i(txv[0]),
    .busy_o(busy[0]), .done_o(done[0]), .rx_data_o(rx0),
    .dc_clk_enable(en[0]), .dc_digital_input(din[0]), .dc_digital_output(dout[0]));

  dc_shift_driver #(.WIDTH(8), .DIV(1), .CORE_DEPTH(3)) u1 (
    .internal_clk(clk), .dc_rst(rst), .start_i(start[1]), .tx_data_i(txv[1]),
    .busy_o(busy[1]), .done_o(done[1]), .rx_data_o(rx1),
    .dc_clk_enable(en[1]), .dc_digital_input(din[1]), .dc_digital_output(dout[1]));

  dc_shift_driver #(.WIDTH(1), .DIV(2), .CORE_DEPTH(1)) u2 (
    .internal_clk(clk), .dc_rst(rst), .start_i(start[2]), .tx_data_i(txv[2][0]),
    .busy_o(busy[2]), .done_o(done[2]), .rx_data_o(rx2b),
    .dc_clk_enable(en[2]), .dc_digital_input(din[2]), .dc_digital_output(dout[2]));

  function automatic logic [7:0] rx_of(input int d);
    return (d == 0) ? rx0 : (d == 1) ? rx1 : {7'b0, rx2b};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transfer on instance d, called at a falling edge. Cycle 0 is the
  // current cycle (start sampled at its end). Optionally re-pulses start
  // with tx=0 at cycle inj to prove it is ignored while busy.
  task automatic xfer(input int d, input logic [7:0] t, input logic [7:0] exp,
                      input int w, input int dv, input int cd, input int inj);
    int         n, last, k, dones, done_c;
    logic       shape_ok, din_ok, busy_ok, hold_ok, exp_en, exp_din;
    logic [7:0] prev;
    n = w + cd;
    last = dv * n;
    dones = 0;
    done_c = -1;
    shape_ok = 1'b1;
    din_ok = 1'b1;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    prev = rx_of(d);
    start[d] = 1'b1;
    txv[d] = t;
    sb.push_back(exp);
    for (int c = 1; c <= last + 2; c++) begin
      @(negedge clk);
      if (c == 1) start[d] = 1'b0;
      if (c == inj) begin
        start[d] = 1'b1;
        txv[d] = 8'h00;
      end
      if (c == inj + 1) start[d] = 1'b0;
      k = (c + dv - 1) / dv;
      exp_en = (c % dv == 0) && (c <= last);
      exp_din = 1'b0;
      if (c <= last && k <= w) exp_din = t[w-k];
      if (en[d] !== exp_en) shape_ok = 1'b0;
      if (din[d] !== exp_din) din_ok = 1'b0;
      if (busy[d] !== (c <= last + 1)) busy_ok = 1'b0;
      if (done[d] === 1'b1) begin
        dones++;
        done_c = c;
        check("sb_nonempty", sb.size(), 1);
        if (sb.size() > 0) check("rx_data", rx_of(d), sb.pop_front());
      end else if (c <= last && rx_of(d) !== prev) begin
        hold_ok = 1'b0;
      end
    end
    if (dones == 0) sb.delete();
    check("strobe_shape", shape_ok, 1);
    check("serial_in", din_ok, 1);
    check("busy_window", busy_ok, 1);
    check("rx_held", hold_ok, 1);
    check("done_count", dones, 1);
    check("done_cycle", done_c, last + 1);
  endtask

  initial begin
    logic dseen;
    rst = 1'b1;
    mode = 0;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      txv[i] = 8'h00;
    end
    #12;
    check("reset_u0", {busy[0], done[0], en[0], din[0], rx0}, 0);
    check("reset_u2", {busy[2], done[2], en[2], din[2], rx2b}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Loopback, then stuck core outputs, then ignored restart and back-to-back.
    xfer(0, 8'hA5, 8'hA5, 8, 4, 3, 0);
    mode = 1;
    xfer(0, 8'h3C, 8'hFF, 8, 4, 3, 0);
    mode = 2;
    xfer(0, 8'hC3, 8'h00, 8, 4, 3, 0);
    mode = 0;
    xfer(0, 8'hA5, 8'hA5, 8, 4, 3, 20);
    xfer(0, 8'h5A, 8'h5A, 8, 4, 3, 0);

    // Reset in the middle of a transfer.
    start[0] = 1'b1;
    txv[0] = 8'hFF;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      if (c == 1) start[0] = 1'b0;
    end
    check("pre_rst_busy", busy[0], 1);
    check("pre_rst_din", din[0], 1);
    #2 rst = 1'b1;
    #1;
    check("rst_outs", {busy[0], en[0], din[0], done[0]}, 0);
    check("rst_rx", rx0, 0);
    dseen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (c == 2) rst = 1'b0;
      if (done[0] === 1'b1 || en[0] === 1'b1) dseen = 1'b1;
    end
    check("no_activity_after_rst", dseen, 0);
    xfer(0, 8'h96, 8'h96, 8, 4, 3, 0);

    // Continuous enable and minimal configuration.
    xfer(1, 8'h3C, 8'h3C, 8, 1, 3, 0);
    xfer(2, 8'h01, 8'h01, 1, 2, 1, 0);
    xfer(2, 8'h00, 8'h00, 1, 2, 1, 0);

    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
